// File: rtl/uop_tc_pkg.sv
// Shared types and constants for the truth-table checker: FSM state encoding
// and the stock two-input expectation vectors (bit k = output for minterm k).
package uop_tc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } tc_state_e;

  localparam logic [3:0] EXP_XNOR2 = 4'b1001;
  localparam logic [3:0] EXP_XOR2  = 4'b0110;
  localparam logic [3:0] EXP_AND2  = 4'b1000;
  localparam logic [3:0] EXP_OR2   = 4'b1110;

endpackage

// File: rtl/uop_truth_checker_if.sv
// Checker-side bus: sweep control, minterm drive to the DUT, DUT response and
// sweep results. master = checker, slave = harness around the DUT under test.
interface uop_truth_checker_if #(
  parameter int unsigned N = 2
);

  logic         start;
  logic [N-1:0] mt;
  logic         yy;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic [N-1:0] fail_mt;

  modport master (
    input  start,
    input  yy,
    output mt,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_mt
  );

  modport slave (
    output start,
    output yy,
    input  mt,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_mt
  );

endinterface

// File: rtl/uop_minterm_counter.sv
// N-bit minterm counter with synchronous clear/enable and an all-ones
// terminal-count flag used to end the sweep without wrapping.
module uop_minterm_counter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [N-1:0] count,
  output logic         tc_c
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + N'(1);
    end
  end

  assign tc_c = (count == {N{1'b1}});

endmodule

// File: rtl/uop_truth_checker.sv
// Exhaustive truth-table checker: sweeps every minterm (one settle cycle, one
// check cycle each) and reports mismatches. Optional macro UOP_TC_STOP_ON_FAIL_EN
// ends the sweep at the first mismatching minterm.
module uop_truth_checker
  import uop_tc_pkg::*;
#(
  parameter int unsigned         N        = 2,
  parameter logic [(2**N)-1:0]   EXPECTED = EXP_XNOR2
) (
  input  logic                clk,
  input  logic                reset,
  uop_truth_checker_if.master bus
);

  localparam int unsigned CW = N + 1;
  localparam logic [CW-1:0] ERR_MAX = CW'(2**N);

`ifdef UOP_TC_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  tc_state_e     state;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [CW-1:0] err_q;
  logic [N-1:0]  fail_q;

  logic [N-1:0]  mt_c;
  logic          tc_c;
  logic          accept_c;
  logic          check_c;
  logic          miss_c;
  logic          last_c;
  logic          inc_c;

  assign accept_c = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign check_c  = (state == ST_CHECK);
  assign miss_c   = check_c && (bus.yy != EXPECTED[mt_c]);
  assign last_c   = tc_c || (STOP_ON_FAIL && miss_c);
  // mt only advances on the CHECK->APPLY edge, so it is stable through CHECK
  assign inc_c    = check_c && !last_c;

  uop_minterm_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (accept_c),
    .en    (inc_c),
    .count (mt_c),
    .tc_c  (tc_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      fail_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept_c) begin
            state  <= ST_APPLY;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            fail_q <= '0;
          end
        end
        ST_APPLY: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (miss_c) begin
            if (err_q != ERR_MAX) begin
              err_q <= err_q + CW'(1);
            end
            if (err_q == '0) begin
              fail_q <= mt_c;
            end
          end
          if (last_c) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_q == '0) && !miss_c;
          end else begin
            state <= ST_APPLY;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mt        = mt_c;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_mt   = fail_q;

endmodule

// File: tb/tb_uop_truth_checker.sv
// Randomized bench for uop_truth_checker: two checkers (N=2 XNOR, N=1 EXPECTED=2'b10)
// face table-driven DUT models; results are predicted from the truth tables directly.
module tb_uop_truth_checker;

  logic clk;
  logic rst2;
  logic rst1;
  logic [3:0] tbl2;
  logic [1:0] tbl1;
  int n_cmp;
  int n_bad;

  localparam logic [3:0] EXP2 = 4'b1001;
  localparam logic [3:0] EXP1 = 4'b0010;

  uop_truth_checker_if #(.N(2)) bus2 ();
  uop_truth_checker_if #(.N(1)) bus1 ();

  uop_truth_checker #(.N(2), .EXPECTED(4'b1001)) u_dut2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (bus2)
  );

  uop_truth_checker #(.N(1), .EXPECTED(2'b10)) u_dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1)
  );

  // DUT under test is just its truth table indexed by the applied minterm
  assign bus2.yy = tbl2[bus2.mt];
  assign bus1.yy = tbl1[bus1.mt];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic obs(input int which, output int m, output int b, output int d,
                     output int p, output int e, output int f);
    if (which == 2) begin
      m = int'(bus2.mt); b = int'(bus2.busy); d = int'(bus2.done);
      p = int'(bus2.pass); e = int'(bus2.err_count); f = int'(bus2.fail_mt);
    end else begin
      m = int'(bus1.mt); b = int'(bus1.busy); d = int'(bus1.done);
      p = int'(bus1.pass); e = int'(bus1.err_count); f = int'(bus1.fail_mt);
    end
  endtask

  task automatic drive_start(input int which, input logic v);
    if (which == 2) bus2.start = v;
    else            bus1.start = v;
  endtask

  task automatic set_tbl(input int which, input logic [3:0] t);
    if (which == 2) tbl2 = t;
    else            tbl1 = t[1:0];
  endtask

  task automatic set_rst(input int which, input logic v);
    if (which == 2) rst2 = v;
    else            rst1 = v;
  endtask

  task automatic check_zero(input int which);
    int m, b, d, p, e, f;
    obs(which, m, b, d, p, e, f);
    check_eq("zero_mt", m, 0);
    check_eq("zero_busy", b, 0);
    check_eq("zero_done", d, 0);
    check_eq("zero_pass", p, 0);
    check_eq("zero_err", e, 0);
    check_eq("zero_fail_mt", f, 0);
  endtask

  // Issue a start (held if hold=1); returns in the first cycle of the sweep.
  task automatic launch(input int which, input bit hold);
    drive_start(which, 1'b1);
    @(negedge clk);
    if (!hold) drive_start(which, 1'b0);
  endtask

  // Follow a sweep from its first cycle to DONE and compare with the table model.
  task automatic check_sweep(input int which, input logic [3:0] tbl, input bit poke,
                             input bit hold, input logic [3:0] tbl_next);
    int nm, errs, first, len, fin_mt, run_err;
    int m, b, d, p, e, f;
    logic [3:0] expv;
    nm    = (which == 2) ? 4 : 2;
    expv  = (which == 2) ? EXP2 : EXP1;
    errs  = 0;
    first = -1;
    for (int k = 0; k < nm; k++) begin
      if (tbl[k] != expv[k]) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    len    = 2 * nm;
    fin_mt = nm - 1;
`ifdef UOP_TC_STOP_ON_FAIL_EN
    if (first >= 0) begin
      len    = 2 * (first + 1);
      errs   = 1;
      fin_mt = first;
    end
`endif
    for (int k = 1; k <= len; k++) begin
      obs(which, m, b, d, p, e, f);
      run_err = 0;
      for (int j = 0; j < (k - 1) / 2; j++) if (tbl[j] != expv[j]) run_err++;
      check_eq("mt_seq", m, (k - 1) / 2);
      check_eq("busy_in_sweep", b, 1);
      check_eq("done_in_sweep", d, 0);
      check_eq("pass_in_sweep", p, 0);
      check_eq("err_running", e, run_err);
      if (poke && !hold) drive_start(which, 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    if (!hold) drive_start(which, 1'b0);
    obs(which, m, b, d, p, e, f);
    check_eq("done_at_end", d, 1);
    check_eq("busy_at_end", b, 0);
    check_eq("err_count", e, errs);
    check_eq("pass", p, (errs == 0) ? 1 : 0);
    check_eq("mt_final", m, fin_mt);
    if (errs > 0) check_eq("fail_mt", f, first);
    if (hold) begin
      set_tbl(which, tbl_next);
      @(negedge clk);
      drive_start(which, 1'b0);
      obs(which, m, b, d, p, e, f);
      check_eq("restart_busy", b, 1);
      check_eq("restart_done", d, 0);
      check_eq("restart_err", e, 0);
      check_eq("restart_pass", p, 0);
      check_eq("restart_mt", m, 0);
    end else begin
      @(negedge clk);
      obs(which, m, b, d, p, e, f);
      check_eq("done_held", d, 1);
      check_eq("mt_held", m, fin_mt);
      check_eq("err_held", e, errs);
    end
  endtask

  // Start a sweep and reset it in cycle rk; no done may follow.
  task automatic abort_sweep(input int which, input int rk);
    int m, b, d, p, e, f;
    launch(which, 1'b0);
    for (int k = 1; k < rk; k++) @(negedge clk);
    set_rst(which, 1'b1);
    drive_start(which, 1'b1);
    @(negedge clk);
    set_rst(which, 1'b0);
    drive_start(which, 1'b0);
    check_zero(which);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      obs(which, m, b, d, p, e, f);
      check_eq("abort_no_done", d, 0);
      check_eq("abort_idle_busy", b, 0);
    end
  endtask

  initial begin
    int which;
    logic [3:0] t, t2;
    n_cmp = 0;
    n_bad = 0;
    rst2 = 1'b1;
    rst1 = 1'b1;
    bus2.start = 1'b0;
    bus1.start = 1'b0;
    tbl2 = EXP2;
    tbl1 = 2'b10;
    repeat (2) @(negedge clk);
    check_zero(2);
    check_zero(1);
    rst2 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    check_zero(2);

    // directed: correct XNOR, XOR, stuck-at-1, busy pokes, back-to-back
    set_tbl(2, 4'b1001); launch(2, 1'b0); check_sweep(2, 4'b1001, 1'b0, 1'b0, 4'b0000);
    set_tbl(2, 4'b0110); launch(2, 1'b0); check_sweep(2, 4'b0110, 1'b1, 1'b0, 4'b0000);
    set_tbl(2, 4'b1111); launch(2, 1'b0); check_sweep(2, 4'b1111, 1'b0, 1'b0, 4'b0000);
    set_tbl(2, 4'b0110); launch(2, 1'b1); check_sweep(2, 4'b0110, 1'b0, 1'b1, 4'b1001);
    check_sweep(2, 4'b1001, 1'b0, 1'b0, 4'b0000);

    // reset in CHECK of minterm 2 (cycle 6)
    abort_sweep(2, 6);

    // N=1: buffer-shaped table matches 2'b10, inverter does not
    set_tbl(1, 4'b0010); launch(1, 1'b0); check_sweep(1, 4'b0010, 1'b0, 1'b0, 4'b0000);
    set_tbl(1, 4'b0001); launch(1, 1'b0); check_sweep(1, 4'b0001, 1'b1, 1'b0, 4'b0000);

    // randomized tables, pokes, back-to-back restarts and aborts
    for (int it = 0; it < 40; it++) begin
      which = (($urandom & 1) != 0) ? 2 : 1;
      t  = 4'($urandom) & ((which == 2) ? 4'hF : 4'h3);
      t2 = 4'($urandom) & ((which == 2) ? 4'hF : 4'h3);
      set_tbl(which, t);
      case ($urandom_range(0, 3))
        0: begin
          launch(which, 1'b1);
          check_sweep(which, t, 1'b0, 1'b1, t2);
          check_sweep(which, t2, 1'b0, 1'b0, 4'b0000);
        end
        1: abort_sweep(which, int'($urandom_range(1, (which == 2) ? 8 : 4)));
        default: begin
          launch(which, 1'b0);
          check_sweep(which, t, 1'($urandom_range(0, 1)), 1'b0, 4'b0000);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
